// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: master indices, arbiter FSM states and the ordered-pick helper
// shared by avalon_ram_arbiter and avalon_arb_grant.
package avalon_arb_pkg;
    localparam int NUM_MST = 3;
    localparam logic [1:0] MST_IBUS  = 2'd0;
    localparam logic [1:0] MST_DBUS  = 2'd1;
    localparam logic [1:0] MST_DEBUG = 2'd2;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // One-hot of the first eligible master in the order a, b, c.
    function automatic logic [NUM_MST-1:0] pick(input logic [NUM_MST-1:0] e, input logic [1:0] a,
                                                input logic [1:0] b, input logic [1:0] c);
        logic [NUM_MST-1:0] o;
        o = '0;
        if (e[a]) o[a] = 1'b1;
        else if (e[b]) o[b] = 1'b1;
        else if (e[c]) o[c] = 1'b1;
        return o;
    endfunction

    function automatic logic [1:0] idx_of(input logic [NUM_MST-1:0] g);
        return g[MST_IBUS] ? MST_IBUS : g[MST_DBUS] ? MST_DBUS : MST_DEBUG;
    endfunction
endpackage

// File: rtl/avalon_arb_grant.sv
// avalon_arb_grant: combinational winner selection over unmasked requests.
// AVALON_ARB_ROUND_ROBIN_EN selects round-robin from ptr; otherwise fixed debug > dbus > ibus.
module avalon_arb_grant
    import avalon_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] req,
    input  logic [NUM_MST-1:0] mask,
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    input  logic [1:0]         ptr,
`endif
    output logic [NUM_MST-1:0] win
);
    logic [NUM_MST-1:0] elig;

    assign elig = req & ~mask;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    // ptr holds the last granted master; search starts right after it
    assign win = ptr == MST_IBUS ? pick(elig, MST_DBUS, MST_DEBUG, MST_IBUS) :
                 ptr == MST_DBUS ? pick(elig, MST_DEBUG, MST_IBUS, MST_DBUS) :
                                   pick(elig, MST_IBUS, MST_DBUS, MST_DEBUG);
`else
    assign win = pick(elig, MST_DEBUG, MST_DBUS, MST_IBUS);
`endif
endmodule

// File: rtl/avalon_ram_arbiter.sv
// avalon_ram_arbiter: shares one Avalon-MM RAM port among ibus, dbus and debug masters.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module avalon_ram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ibus_avn_read,
    input  logic            ibus_avn_write,
    input  logic [AW-1:0]   ibus_avn_address,
    input  logic [DW/8-1:0] ibus_avn_byte_enable,
    input  logic [DW-1:0]   ibus_avn_writedata,
    output logic [DW-1:0]   ibus_avn_readdata,
    output logic            ibus_avn_waitrequest,
    input  logic            dbus_avn_read,
    input  logic            dbus_avn_write,
    input  logic [AW-1:0]   dbus_avn_address,
    input  logic [DW/8-1:0] dbus_avn_byte_enable,
    input  logic [DW-1:0]   dbus_avn_writedata,
    output logic [DW-1:0]   dbus_avn_readdata,
    output logic            dbus_avn_waitrequest,
    input  logic            debug_avn_read,
    input  logic            debug_avn_write,
    input  logic [AW-1:0]   debug_avn_address,
    input  logic [DW/8-1:0] debug_avn_byte_enable,
    input  logic [DW-1:0]   debug_avn_writedata,
    output logic [DW-1:0]   debug_avn_readdata,
    output logic            debug_avn_waitrequest,
    output logic            ram_avn_read,
    output logic            ram_avn_write,
    output logic [AW-1:0]   ram_avn_address,
    output logic [DW/8-1:0] ram_avn_byte_enable,
    output logic [DW-1:0]   ram_avn_writedata,
    input  logic [DW-1:0]   ram_avn_readdata,
    input  logic            ram_avn_waitrequest
);
    import avalon_arb_pkg::*;

    arb_state_t         state, state_nxt;
    logic [NUM_MST-1:0] req, grant, win, mask;
    logic               done, abort, load;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    logic [1:0]         ptr;
`endif

    assign req   = {debug_avn_read | debug_avn_write, dbus_avn_read | dbus_avn_write,
                    ibus_avn_read | ibus_avn_write};
    assign done  = state == ARB_BUSY && !ram_avn_waitrequest;
    assign abort = state == ARB_BUSY && !(|(req & grant));
    // the finishing master is excluded so another master can take over without a gap
    assign mask  = state == ARB_BUSY ? grant : '0;
    assign load  = state == ARB_IDLE ? |req : done && !abort;

    avalon_arb_grant u_grant (
        .req  (req),
        .mask (mask),
`ifdef AVALON_ARB_ROUND_ROBIN_EN
        .ptr  (ptr),
`endif
        .win  (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == ARB_IDLE ? (|req ? ARB_BUSY : ARB_IDLE) :
                    abort             ? ARB_IDLE :
                    done && !(|win)   ? ARB_IDLE : ARB_BUSY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) grant <= '0;
        else if (abort) grant <= '0;
        else if (load) grant <= win;
    end

`ifdef AVALON_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= MST_DEBUG;
        else if (load && |win) ptr <= idx_of(win);
    end
`endif

    // grant is zero outside BUSY, so the AND-OR mux also yields the idle zeros
    always_comb begin
        ram_avn_read          = |(grant & {debug_avn_read, dbus_avn_read, ibus_avn_read});
        ram_avn_write         = |(grant & {debug_avn_write, dbus_avn_write, ibus_avn_write});
        ram_avn_address       = ({AW{grant[MST_IBUS]}} & ibus_avn_address) |
                                ({AW{grant[MST_DBUS]}} & dbus_avn_address) |
                                ({AW{grant[MST_DEBUG]}} & debug_avn_address);
        ram_avn_byte_enable   = ({(DW/8){grant[MST_IBUS]}} & ibus_avn_byte_enable) |
                                ({(DW/8){grant[MST_DBUS]}} & dbus_avn_byte_enable) |
                                ({(DW/8){grant[MST_DEBUG]}} & debug_avn_byte_enable);
        ram_avn_writedata     = ({DW{grant[MST_IBUS]}} & ibus_avn_writedata) |
                                ({DW{grant[MST_DBUS]}} & dbus_avn_writedata) |
                                ({DW{grant[MST_DEBUG]}} & debug_avn_writedata);
        ibus_avn_waitrequest  = grant[MST_IBUS] ? ram_avn_waitrequest : 1'b1;
        dbus_avn_waitrequest  = grant[MST_DBUS] ? ram_avn_waitrequest : 1'b1;
        debug_avn_waitrequest = grant[MST_DEBUG] ? ram_avn_waitrequest : 1'b1;
    end

    assign ibus_avn_readdata  = ram_avn_readdata;
    assign dbus_avn_readdata  = ram_avn_readdata;
    assign debug_avn_readdata = ram_avn_readdata;
endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// tb_avalon_ram_arbiter: vector table of request mixes checked against a grant-order
// scoreboard, plus hand sequences for stall, reset-while-busy and abort.
module tb_avalon_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd [3];
    logic        wr [3];
    logic [31:0] addr [3];
    logic [3:0]  be [3];
    logic [31:0] wd [3];
    logic [31:0] rdt [3];
    logic        wt [3];
    logic        ram_read, ram_write, ram_wait;
    logic [31:0] ram_address, ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    int          checks = 0;
    int          errors = 0;
    int          q [$];
    int          cnt [3];

    typedef struct {
        logic [2:0] req;
        int         n;
        string      ord;
        int         cyc;
    } vec_t;
    vec_t v [6];

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_model(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : ~a;
    endfunction

    assign ram_rdata = ram_model(ram_address);

    avalon_ram_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .ibus_avn_read(rd[0]), .ibus_avn_write(wr[0]), .ibus_avn_address(addr[0]),
        .ibus_avn_byte_enable(be[0]), .ibus_avn_writedata(wd[0]),
        .ibus_avn_readdata(rdt[0]), .ibus_avn_waitrequest(wt[0]),
        .dbus_avn_read(rd[1]), .dbus_avn_write(wr[1]), .dbus_avn_address(addr[1]),
        .dbus_avn_byte_enable(be[1]), .dbus_avn_writedata(wd[1]),
        .dbus_avn_readdata(rdt[1]), .dbus_avn_waitrequest(wt[1]),
        .debug_avn_read(rd[2]), .debug_avn_write(wr[2]), .debug_avn_address(addr[2]),
        .debug_avn_byte_enable(be[2]), .debug_avn_writedata(wd[2]),
        .debug_avn_readdata(rdt[2]), .debug_avn_waitrequest(wt[2]),
        .ram_avn_read(ram_read), .ram_avn_write(ram_write), .ram_avn_address(ram_address),
        .ram_avn_byte_enable(ram_be), .ram_avn_writedata(ram_wdata),
        .ram_avn_readdata(ram_rdata), .ram_avn_waitrequest(ram_wait)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_masters();
        for (int m = 0; m < 3; m++) begin
            rd[m] = 1'b0;
            wr[m] = 1'b0;
            be[m] = 4'hF;
            wd[m] = 32'h0;
        end
        addr[0] = 32'h1000;
        addr[1] = 32'h100;
        addr[2] = 32'h2000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_masters();
        ram_wait = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ram_read"}, ram_read, 0);
        chk({tag, "_ram_write"}, ram_write, 0);
        chk({tag, "_ram_addr"}, ram_address, 0);
        chk({tag, "_ram_be"}, ram_be, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_waits"}, {wt[0], wt[1], wt[2]}, 3'b111);
    endtask

    // Completion monitor: a master with a request and waitrequest low finishes at the next edge.
    task automatic monitor(output logic [2:0] fin);
        int nlow;
        fin = '0;
        nlow = 0;
        for (int m = 0; m < 3; m++) begin
            if (!wt[m]) nlow++;
            if (rd[m] && !wt[m]) begin
                chk("order", m, q.size() > 0 ? q.pop_front() : 9);
                chk("rdata", rdt[m], ram_model(addr[m]));
                chk("ram_addr", ram_address, addr[m]);
                cnt[m]--;
                if (cnt[m] == 0) fin[m] = 1'b1;
            end
        end
        chk("single_grant", nlow <= 1, 1);
    endtask

    initial begin
        logic [2:0] fin;
        int iters;
        clear_masters();
        ram_wait = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_rdata", rdt[1], 32'hFFFFFFFF);
        rst = 1'b0;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
        v[0] = '{3'b010, 1, "1", 2};
        v[1] = '{3'b011, 1, "01", 3};
        v[2] = '{3'b111, 2, "012012", 7};
        v[3] = '{3'b101, 1, "02", 3};
        v[4] = '{3'b001, 3, "000", 6};
        v[5] = '{3'b110, 2, "1212", 5};
`else
        v[0] = '{3'b010, 1, "1", 2};
        v[1] = '{3'b011, 1, "10", 3};
        v[2] = '{3'b111, 2, "212100", 8};
        v[3] = '{3'b101, 1, "20", 3};
        v[4] = '{3'b001, 3, "000", 6};
        v[5] = '{3'b110, 2, "2121", 5};
`endif

        for (int i = 0; i < 6; i++) begin
            do_reset();
            q.delete();
            for (int k = 0; k < v[i].ord.len(); k++) q.push_back(int'(v[i].ord[k]) - 48);
            @(posedge clk);
            #1;
            for (int m = 0; m < 3; m++) begin
                rd[m] = v[i].req[m];
                cnt[m] = v[i].req[m] ? v[i].n : 0;
            end
            iters = 0;
            while (iters < 30) begin
                @(negedge clk);
                monitor(fin);
                iters++;
                if (cnt[0] + cnt[1] + cnt[2] == 0) break;
                @(posedge clk);
                #1;
                for (int m = 0; m < 3; m++) if (fin[m]) rd[m] = 1'b0;
            end
            @(posedge clk);
            #1;
            clear_masters();
            chk("vec_cycles", iters, v[i].cyc);
            chk("vec_queue_empty", q.size(), 0);
        end

        // Stalled dbus write: grant and outputs hold, ibus waits until completion.
        do_reset();
        @(posedge clk);
        #1;
        wr[1] = 1'b1;
        addr[1] = 32'h40;
        wd[1] = 32'hCAFE0000;
        be[1] = 4'h3;
        ram_wait = 1'b1;
        @(posedge clk);
        #1;
        rd[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_write", ram_write, 1);
            chk("stall_read", ram_read, 0);
            chk("stall_addr", ram_address, 32'h40);
            chk("stall_wdata", ram_wdata, 32'hCAFE0000);
            chk("stall_be", ram_be, 4'h3);
            chk("stall_waits", {wt[0], wt[1], wt[2]}, 3'b111);
            @(posedge clk);
            #1;
        end
        ram_wait = 1'b0;
        @(negedge clk);
        chk("stall_done_waits", {wt[0], wt[1], wt[2]}, 3'b101);
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        @(negedge clk);
        chk("handover_read", ram_read, 1);
        chk("handover_write", ram_write, 0);
        chk("handover_addr", ram_address, 32'h1000);
        chk("handover_waits", {wt[0], wt[1], wt[2]}, 3'b011);
        @(posedge clk);
        #1;
        clear_masters();

        // Reset while busy: outputs drop at once, a held request is granted after release.
        do_reset();
        @(posedge clk);
        #1;
        rd[1] = 1'b1;
        ram_wait = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_before_rst", ram_read, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ram_wait = 1'b0;
        @(negedge clk);
        chk("post_rst_read", ram_read, 1);
        chk("post_rst_addr", ram_address, 32'h100);
        chk("post_rst_waits", {wt[0], wt[1], wt[2]}, 3'b101);
        chk("post_rst_rdata", rdt[1], 32'hDEADBEEF);
        @(posedge clk);
        #1;
        clear_masters();

        // Abort: granted ibus drops read mid-stall, pending debug follows one idle cycle later.
        do_reset();
        @(posedge clk);
        #1;
        rd[0] = 1'b1;
        ram_wait = 1'b1;
        @(posedge clk);
        #1;
        rd[2] = 1'b1;
        @(negedge clk);
        chk("abort_granted_addr", ram_address, 32'h1000);
        chk("abort_debug_wait", wt[2], 1);
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        @(negedge clk);
        chk("abort_drop_read", ram_read, 0);
        @(posedge clk);
        #1;
        ram_wait = 1'b0;
        @(negedge clk);
        chk("abort_idle_read", ram_read, 0);
        chk("abort_idle_waits", {wt[0], wt[1], wt[2]}, 3'b111);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_debug_read", ram_read, 1);
        chk("abort_debug_addr", ram_address, 32'h2000);
        chk("abort_debug_waits", {wt[0], wt[1], wt[2]}, 3'b110);
        @(posedge clk);
        #1;
        clear_masters();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_ram_arbiter.md
# avalon_ram_arbiter

Three-master to one-slave Avalon-MM arbiter that shares the main memory port among the instruction bus, data bus and debug bus. It sits between the SoC masters and the `avalon_ram_1rw` main memory instance. It holds a registered grant per transaction, forwards the granted master's request to the RAM, and returns `waitrequest`/`readdata`.

## Interface
- `AW`, 32, address width of all ports
- `DW`, 32, data width; byte_enable width is DW/8
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `<m>_avn_read`, `<m>_avn_write`  in  1 each  master request, for m ∈ {ibus, dbus, debug}
- `<m>_avn_address`  in  AW  master address
- `<m>_avn_byte_enable`  in  DW/8  master byte enables
- `<m>_avn_writedata`  in  DW  master write data
- `<m>_avn_readdata`  out  DW  read data returned to the master
- `<m>_avn_waitrequest`  out  1  master stall
- `ram_avn_read`, `ram_avn_write`  out  1 each  slave request
- `ram_avn_address`  out  AW  slave address
- `ram_avn_byte_enable`  out  DW/8  slave byte enables
- `ram_avn_writedata`  out  DW  slave write data
- `ram_avn_readdata`  in  DW  slave read data
- `ram_avn_waitrequest`  in  1  slave stall

## Operation
- Request of master m: `req[m] = m_avn_read | m_avn_write`. Masters hold all request signals stable until their waitrequest is low (Avalon rule).
- FSM states:
  - IDLE: no grant.
  - BUSY: the `grant` register (one-hot, 3 bits) selects one master.
- IDLE:
  - If any req is set, compute the winner, load `grant`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - All `ram_avn_*` request outputs equal the granted master's inputs.
  - Granted master's waitrequest = `ram_avn_waitrequest`.
- Completion is a cycle in BUSY with `ram_avn_waitrequest`=0.
  - On completion, re-arbitrate among the non-granted masters only. The completing master's req is masked because it belongs to the finished transfer.
  - If there is a winner, load the new `grant` and stay in BUSY (back-to-back hand-over). If not, go to IDLE.
- Abort: if the granted master drops req in BUSY before completion (a protocol violation), go to IDLE next cycle. No transfer is counted.
- Non-granted masters: waitrequest=1.
- `ram_avn_readdata` is broadcast combinationally to all `<m>_avn_readdata`. Only the granted master samples it.
- IDLE slave outputs: read=0, write=0, address=0, byte_enable=0, writedata=0.
- A master asserting read and write together is forwarded as-is; the arbiter does not check it.

## Timing
- Reset values:
  - state=IDLE, grant=0, RR pointer=debug.
  - All ram request outputs 0.
  - All master waitrequest=1.
  - readdata follows `ram_avn_readdata`.
- Arbitration latency is 1 cycle:
  - Request at cycle N in IDLE → slave sees it at N+1.
  - With a 0-wait slave, the master sees waitrequest=0 at N+1.
- Back-to-back different masters: no idle cycle between transfers.
- A single master streaming: 2 cycles per transfer (completion → IDLE → re-grant).
- Reset asserted mid-transfer: state returns to IDLE immediately. Slave request outputs drop asynchronously. The pending transfer is lost.

## Configuration
- `AVALON_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin.
  - Priority starts at the master after the last granted one (order ibus→dbus→debug→ibus).
  - The pointer updates on each grant load.
  - Reset order: ibus > dbus > debug.
- Undefined:
  - Fixed priority debug > dbus > ibus.
  - No pointer register.

## Structure
- Package `avalon_arb_pkg` holds:
  - master indices `MST_IBUS`=0, `MST_DBUS`=1, `MST_DEBUG`=2, `NUM_MST`=3
  - state enum `ARB_IDLE`/`ARB_BUSY`
- Sub-module `avalon_arb_grant`: combinational winner selection (req vector, mask, pointer → one-hot), containing the macro-selected policy.
- Top level: FSM, grant/pointer registers, mux.

## Test plan
- Single dbus read of 0x100 (RAM holds 0xDEADBEEF):
  - `ram_avn_read`=1 one cycle after the request.
  - dbus waitrequest low with readdata 0xDEADBEEF.
  - ibus and debug waitrequest stay 1.
- ibus and dbus request simultaneously from IDLE:
  - Round-robin after reset: ibus served first, dbus handed over in the completion cycle with no gap.
  - Fixed priority: dbus first.
- All three masters request continuously:
  - Round-robin: grant order ibus, dbus, debug, ibus…
  - Fixed priority: debug is served whenever it requests, at the completion cycle or from IDLE.
- RAM holds waitrequest=1 for 3 cycles on a dbus write of 0xCAFE0000 with byte_enable 0x3:
  - Grant is held.
  - Outputs are stable.
  - No other master is granted until completion.
- Reset asserted while BUSY:
  - All ram outputs are 0 and all waitrequests are 1 in the same cycle.
  - After release, a new request is granted normally.
- Granted ibus drops read mid-stall:
  - Arbiter returns to IDLE next cycle.
  - A pending debug request is granted the cycle after.
